// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 burst memory responder.
// Response codes are ordered by severity so that merging is a simple maximum.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  // Higher encoding is the more severe response: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    resp_merge = (a > b) ? a : b;
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok = 1'b1;
      default:                 wrap_len_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next-beat address, last-beat detect, range check and burst legality for the active burst.
// WRAP bursts are legal only when AXI_MEM_WRAP_EN is defined; otherwise WRAP is treated as reserved.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int STRB_W    = 32,
  parameter int MEM_BYTES = 65536
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [7:0]        beat,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              is_last,
  output logic              in_range,
  output logic              legal
);

  localparam int OFF_W = $clog2(STRB_W);

  logic [ADDR_W-1:0] incr_s;

  assign incr_s   = addr + ADDR_W'(STRB_W);
  assign is_last  = (beat == len);
  assign in_range = (addr < ADDR_W'(MEM_BYTES));

`ifdef AXI_MEM_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask_s;
  assign wrap_mask_s = ((ADDR_W'(len) + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
`endif

  // Address step and legality per burst type
  always_comb begin
    next_addr = addr;
    legal     = 1'b0;
    case (burst)
      BURST_FIXED: begin
        next_addr = addr;
        legal     = 1'b1;
      end
      BURST_INCR: begin
        next_addr = incr_s;
        legal     = 1'b1;
      end
`ifdef AXI_MEM_WRAP_EN
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
        legal     = wrap_len_ok(len);
      end
`endif
      default: begin
        next_addr = addr;
        legal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 burst memory responder over a word-addressed RAM, one transaction at a time.
// Define AXI_MEM_WRAP_EN to support WRAP bursts (lengths 2/4/8/16 beats).
module axi_burst_mem
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 65536
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [7:0]          awlen_i,
  input  logic [1:0]          awburst_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [1:0]          bresp_o,
  output logic [ID_W-1:0]     bid_o,
  input  logic                arvalid_i,
  output logic                arready_o,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [7:0]          arlen_i,
  input  logic [1:0]          arburst_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic [ID_W-1:0]     rid_o,
  output logic                rlast_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WORDS  = MEM_BYTES / STRB_W;
  localparam int IDX_W  = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

  logic [DATA_W-1:0] mem [WORDS];

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ID_W-1:0]   id_r;
  logic [7:0]        len_r;
  logic [7:0]        beat_r;
  logic [1:0]        burst_r;
  logic [1:0]        resp_r;
  logic [1:0]        bresp_r;
  logic              wready_r;
  logic              bvalid_r;
  logic              rvalid_r;

  logic [ADDR_W-1:0] next_addr_s;
  logic              last_s;
  logic              in_range_s;
  logic              legal_s;
  logic [1:0]        beat_resp_s;
  logic [1:0]        wr_resp_s;
  logic [IDX_W-1:0]  idx_s;
  logic              wr_en_s;

  axi_mem_addr_gen #(
    .ADDR_W    (ADDR_W),
    .STRB_W    (STRB_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_addr_gen (
    .addr      (addr_r),
    .len       (len_r),
    .beat      (beat_r),
    .burst     (burst_r),
    .next_addr (next_addr_s),
    .is_last   (last_s),
    .in_range  (in_range_s),
    .legal     (legal_s)
  );

  assign idx_s = addr_r[OFF_W +: IDX_W];

  // Per-beat response; a wlast that disagrees with the beat count adds SLVERR
  always_comb begin
    beat_resp_s = RESP_OKAY;
    if (!in_range_s) begin
      beat_resp_s = RESP_DECERR;
    end else if (!legal_s) begin
      beat_resp_s = RESP_SLVERR;
    end else begin
      beat_resp_s = RESP_OKAY;
    end
    wr_resp_s = beat_resp_s;
    if (wlast_i != last_s) begin
      wr_resp_s = resp_merge(beat_resp_s, RESP_SLVERR);
    end else begin
      wr_resp_s = beat_resp_s;
    end
  end

  assign wr_en_s = rst_ni && (state_r == WR_DATA) && wvalid_i && in_range_s && legal_s;

  // Byte-enabled RAM write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem[idx_s][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      id_r     <= '0;
      len_r    <= 8'd0;
      beat_r   <= 8'd0;
      burst_r  <= BURST_FIXED;
      resp_r   <= RESP_OKAY;
      bresp_r  <= RESP_OKAY;
      wready_r <= 1'b0;
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (awvalid_i) begin
            addr_r   <= awaddr_i & ALIGN_MASK;
            id_r     <= awid_i;
            len_r    <= awlen_i;
            burst_r  <= awburst_i;
            beat_r   <= 8'd0;
            resp_r   <= RESP_OKAY;
            wready_r <= 1'b1;
            state_r  <= WR_DATA;
          end else if (arvalid_i) begin
            addr_r   <= araddr_i & ALIGN_MASK;
            id_r     <= arid_i;
            len_r    <= arlen_i;
            burst_r  <= arburst_i;
            beat_r   <= 8'd0;
            rvalid_r <= 1'b1;
            state_r  <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (wvalid_i) begin
            resp_r <= resp_merge(resp_r, wr_resp_s);
            addr_r <= next_addr_s;
            beat_r <= beat_r + 8'd1;
            if (last_s) begin
              bresp_r  <= resp_merge(resp_r, wr_resp_s);
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              state_r  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RD_DATA: begin
          if (rready_i) begin
            if (last_s) begin
              rvalid_r <= 1'b0;
              state_r  <= IDLE;
            end else begin
              addr_r <= next_addr_s;
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          wready_r <= 1'b0;
          bvalid_r <= 1'b0;
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Address acceptance is same-cycle so a waiting master is never stalled a cycle
  assign awready_o = rst_ni & (state_r == IDLE) & awvalid_i;
  assign arready_o = rst_ni & (state_r == IDLE) & arvalid_i & ~awvalid_i;

  assign wready_o = wready_r;
  assign bvalid_o = bvalid_r;
  assign bresp_o  = bresp_r;
  assign bid_o    = id_r;
  assign rvalid_o = rvalid_r;
  assign rid_o    = id_r;
  assign rlast_o  = rvalid_r & last_s;
  assign rresp_o  = rvalid_r ? beat_resp_s : RESP_OKAY;
  assign rdata_o  = (rvalid_r && (beat_resp_s == RESP_OKAY)) ? mem[idx_s] : '0;

endmodule

// File: tb/tb_axi_burst_mem.sv
// Scoreboard bench for axi_burst_mem: drivers push expected B/R responses, a negedge monitor checks them.
module tb_axi_burst_mem;
  import axi_mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;
  localparam int ID_W   = 4;

  localparam logic [DATA_W-1:0] DA = {8{32'hA0A0_0001}};
  localparam logic [DATA_W-1:0] DB = {8{32'hB0B0_0002}};
  localparam logic [DATA_W-1:0] DC = {8{32'hC0C0_0003}};
  localparam logic [DATA_W-1:0] DD = {8{32'hD0D0_0004}};
  localparam logic [DATA_W-1:0] DE = {8{32'hE0E0_0005}};
  localparam logic [DATA_W-1:0] W0 = {8{32'h1111_0000}};
  localparam logic [DATA_W-1:0] W1 = {8{32'h2222_0001}};
  localparam logic [DATA_W-1:0] W2 = {8{32'h3333_0002}};
  localparam logic [DATA_W-1:0] W3 = {8{32'h4444_0003}};
  localparam logic [DATA_W-1:0] ALL_F = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO  = {DATA_W{1'b0}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic awvalid, awready; logic [ADDR_W-1:0] awaddr; logic [ID_W-1:0] awid;
  logic [7:0] awlen; logic [1:0] awburst;
  logic wvalid, wready; logic [DATA_W-1:0] wdata; logic [DATA_W/8-1:0] wstrb; logic wlast;
  logic bvalid, bready; logic [1:0] bresp; logic [ID_W-1:0] bid;
  logic arvalid, arready; logic [ADDR_W-1:0] araddr; logic [ID_W-1:0] arid;
  logic [7:0] arlen; logic [1:0] arburst;
  logic rvalid, rready; logic [DATA_W-1:0] rdata; logic [1:0] rresp; logic [ID_W-1:0] rid; logic rlast;

  axi_burst_mem dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awid_i(awid),
    .awlen_i(awlen), .awburst_i(awburst),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp), .bid_o(bid),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arid_i(arid),
    .arlen_i(arlen), .arburst_i(arburst),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .rid_o(rid), .rlast_o(rlast)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic [ID_W-1:0]   id;
    logic              last;
  } r_exp_t;

  typedef struct packed {
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  r_exp_t r_e;
  b_exp_t b_e;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] wbuf [16];

  // Monitor: every handshake on B or R is matched against the head of its queue
  always @(negedge clk) begin
    if (bvalid && bready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got resp=%0h id=%0h", bresp, bid);
      end else begin
        b_e = b_q.pop_front();
        if (bresp !== b_e.resp || bid !== b_e.id) begin
          errors++;
          $display("FAIL b_resp got resp=%0h id=%0h expected resp=%0h id=%0h", bresp, bid, b_e.resp, b_e.id);
        end
      end
    end
    if (rvalid && rready) begin
      checks++;
      if (r_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got data=%0h resp=%0h", rdata, rresp);
      end else begin
        r_e = r_q.pop_front();
        if (rdata !== r_e.data || rresp !== r_e.resp || rid !== r_e.id || rlast !== r_e.last) begin
          errors++;
          $display("FAIL r_beat got data=%0h resp=%0h id=%0h last=%0b expected data=%0h resp=%0h id=%0h last=%0b",
                   rdata, rresp, rid, rlast, r_e.data, r_e.resp, r_e.id, r_e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [DATA_W-1:0] d, input logic [1:0] resp, input logic [ID_W-1:0] id, input logic last);
    r_exp_t e;
    e.data = d; e.resp = resp; e.id = id; e.last = last;
    r_q.push_back(e);
  endtask

  // Wait for a ready (0=aw, 1=w, 2=ar), then step past the accepting edge
  task automatic wait_hs(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((sel == 0 && awready === 1'b1) || (sel == 1 && wready === 1'b1) || (sel == 2 && arready === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s handshake timeout", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (b_q.size() == 0 && r_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s response timeout pending b=%0d r=%0d", name, b_q.size(), r_q.size());
      b_q.delete(); r_q.delete();
    end
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [DATA_W/8-1:0] strb, input bit early_last,
                          input logic [1:0] exp_resp);
    b_exp_t e;
    e.resp = exp_resp; e.id = id;
    b_q.push_back(e);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
    wait_hs(0, "aw");
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb;
      wlast = early_last ? (i == 0) : (i == int'(len));
      wait_hs(1, "w");
    end
    wvalid = 1'b0; wlast = 1'b0;
    drain("write");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    @(posedge clk); #1;
    rready = 1'b1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
    wait_hs(2, "ar");
    arvalid = 1'b0;
    drain("read");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bready = 1'b1; rready = 1'b0;
    awvalid = 1'b1; awaddr = '0; awid = '0; awlen = 8'd0; awburst = BURST_INCR;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    arvalid = 1'b1; araddr = '0; arid = '0; arlen = 8'd0; arburst = BURST_INCR;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp_rresp_rlast", {bresp, rresp, rlast}, 0);
    chk("rst_rdata", rdata, 0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: INCR write then read back
    wbuf[0] = DA; wbuf[1] = DB;
    do_write(32'h0000_1000, 4'h3, 8'd1, BURST_INCR, '1, 1'b0, RESP_OKAY);
    push_r(DA, RESP_OKAY, 4'h5, 1'b0);
    push_r(DB, RESP_OKAY, 4'h5, 1'b1);
    do_read(32'h0000_1000, 4'h5, 8'd1, BURST_INCR);

    // 2: partial strobe over a zeroed word
    wbuf[0] = ZERO;
    do_write(32'h0000_2000, 4'h1, 8'd0, BURST_INCR, '1, 1'b0, RESP_OKAY);
    wbuf[0] = ALL_F;
    do_write(32'h0000_2000, 4'h2, 8'd0, BURST_INCR, 32'h0000_00FF, 1'b0, RESP_OKAY);
    push_r({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, RESP_OKAY, 4'h2, 1'b1);
    do_read(32'h0000_2000, 4'h2, 8'd0, BURST_INCR);

    // 3: AW and AR together; write wins, read sees new data
    b_e.resp = RESP_OKAY; b_e.id = 4'h6;
    b_q.push_back(b_e);
    push_r(DC, RESP_OKAY, 4'h7, 1'b1);
    @(posedge clk); #1;
    rready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h0000_3000; awid = 4'h6; awlen = 8'd0; awburst = BURST_INCR;
    arvalid = 1'b1; araddr = 32'h0000_3000; arid = 4'h7; arlen = 8'd0; arburst = BURST_INCR;
    @(negedge clk);
    chk("tie_awready", awready, 1);
    chk("tie_arready", arready, 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = DC; wstrb = '1; wlast = 1'b1;
    @(negedge clk);
    chk("ar_blocked_wdata", arready, 0);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("ar_blocked_bresp", arready, 0);
    @(posedge clk); #1;
    wait_hs(2, "tie_ar");
    arvalid = 1'b0;
    drain("tie");

    // wlast early and missing -> SLVERR, data still written
    wbuf[0] = DD; wbuf[1] = DE;
    do_write(32'h0000_4000, 4'h8, 8'd1, BURST_INCR, '1, 1'b1, RESP_SLVERR);
    push_r(DD, RESP_OKAY, 4'h8, 1'b0);
    push_r(DE, RESP_OKAY, 4'h8, 1'b1);
    do_read(32'h0000_4000, 4'h8, 8'd1, BURST_INCR);

    // 4: out-of-range beats
    push_r(ZERO, RESP_DECERR, 4'h1, 1'b1);
    do_read(32'h0001_0000, 4'h1, 8'd0, BURST_INCR);
    wbuf[0] = DD; wbuf[1] = DE;
    do_write(32'h0000_FFE0, 4'h4, 8'd1, BURST_INCR, '1, 1'b0, RESP_DECERR);
    push_r(DD, RESP_OKAY, 4'h4, 1'b0);
    push_r(ZERO, RESP_DECERR, 4'h4, 1'b1);
    do_read(32'h0000_FFE0, 4'h4, 8'd1, BURST_INCR);

    // FIXED burst: both beats hit the same word
    wbuf[0] = DA; wbuf[1] = DB;
    do_write(32'h0000_5000, 4'h9, 8'd1, BURST_FIXED, '1, 1'b0, RESP_OKAY);
    push_r(DB, RESP_OKAY, 4'h9, 1'b0);
    push_r(DB, RESP_OKAY, 4'h9, 1'b1);
    do_read(32'h0000_5000, 4'h9, 8'd1, BURST_FIXED);

    // 5: WRAP read over four known words
    wbuf[0] = W0; wbuf[1] = W1; wbuf[2] = W2; wbuf[3] = W3;
    do_write(32'h0000_1000, 4'hA, 8'd3, BURST_INCR, '1, 1'b0, RESP_OKAY);
`ifdef AXI_MEM_WRAP_EN
    push_r(W2, RESP_OKAY, 4'hB, 1'b0);
    push_r(W3, RESP_OKAY, 4'hB, 1'b0);
    push_r(W0, RESP_OKAY, 4'hB, 1'b0);
    push_r(W1, RESP_OKAY, 4'hB, 1'b1);
`else
    for (int i = 0; i < 4; i++) push_r(ZERO, RESP_SLVERR, 4'hB, (i == 3));
`endif
    do_read(32'h0000_1040, 4'hB, 8'd3, BURST_WRAP);

    // Reserved burst: SLVERR, no write, rdata 0
    wbuf[0] = ALL_F;
    do_write(32'h0000_1000, 4'hC, 8'd0, 2'b11, '1, 1'b0, RESP_SLVERR);
    push_r(ZERO, RESP_SLVERR, 4'hC, 1'b0);
    push_r(ZERO, RESP_SLVERR, 4'hC, 1'b1);
    do_read(32'h0000_1000, 4'hC, 8'd1, 2'b11);
    push_r(W0, RESP_OKAY, 4'hC, 1'b1);
    do_read(32'h0000_1000, 4'hC, 8'd0, BURST_INCR);

    // 6a: stall mid-burst, R outputs must hold
    push_r(W0, RESP_OKAY, 4'hD, 1'b0);
    push_r(W1, RESP_OKAY, 4'hD, 1'b0);
    push_r(W2, RESP_OKAY, 4'hD, 1'b0);
    push_r(W3, RESP_OKAY, 4'hD, 1'b1);
    @(posedge clk); #1;
    rready = 1'b0;
    arvalid = 1'b1; araddr = 32'h0000_1000; arid = 4'hD; arlen = 8'd3; arburst = BURST_INCR;
    wait_hs(2, "stall_ar");
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, W1);
      chk("stall_rlast_rid", {rlast, rid}, {1'b0, 4'hD});
    end
    @(posedge clk); #1;
    rready = 1'b1;
    drain("stall");

    // 6b: reset at beat 2 of 4
    push_r(W0, RESP_OKAY, 4'hE, 1'b0);
    push_r(W1, RESP_OKAY, 4'hE, 1'b0);
    push_r(W2, RESP_OKAY, 4'hE, 1'b0);
    push_r(W3, RESP_OKAY, 4'hE, 1'b1);
    @(posedge clk); #1;
    rready = 1'b1;
    arvalid = 1'b1; araddr = 32'h0000_1000; arid = 4'hE; arlen = 8'd3; arburst = BURST_INCR;
    wait_hs(2, "rst_ar");
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; rready = 1'b0;
    arvalid = 1'b1; araddr = 32'h0000_1020; arid = 4'hF; arlen = 8'd0; arburst = BURST_INCR;
    @(negedge clk);
    chk("mid_rst_arready", arready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_arready", arready, 0);
    chk("rst_pending_beats", r_q.size(), 2);
    r_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rready = 1'b1;
    push_r(W1, RESP_OKAY, 4'hF, 1'b1);
    @(negedge clk);
    chk("release_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
